// File: rtl/async_reg.sv
`timescale 1ns/1ps
// async_reg: parameterised holding register. Reset asserts asynchronously
// and releases through a short synchroniser so capture restarts on a known edge.
module async_reg #(
    parameter int unsigned      WIDTH           = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0,
    parameter int unsigned      RST_SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic             w_rst_i;
    logic [WIDTH-1:0] r_data;

    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("async_reg: WIDTH must be 1..64");
        end
        if (RST_SYNC_STAGES > 4) begin : g_bad_depth
            $error("async_reg: RST_SYNC_STAGES must be 0..4");
        end

        if (RST_SYNC_STAGES == 0) begin : g_raw_rst
            assign w_rst_i = rst;
        end else begin : g_sync_rst
            // Every stage is set by rst; zeros ripple toward the top bit.
            logic [RST_SYNC_STAGES-1:0] r_sync;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync <= {RST_SYNC_STAGES{1'b1}};
                end else begin
                    r_sync <= r_sync << 1;
                end
            end

            assign w_rst_i = r_sync[RST_SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge w_rst_i) begin
        if (w_rst_i) begin
            r_data <= RESET_VALUE;
        end else begin
            r_data <= data_in;
        end
    end

    assign data_out = r_data;

endmodule

// File: tb/tb_async_reg.sv
`timescale 1ns/1ps
// tb_async_reg: vector table, hand-written reset corner cases and a
// randomized run against a release-counting reference model.
module tb_async_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  d8  = 8'h00;
    logic [15:0] d16 = 16'h0000;
    logic [7:0]  q8;
    logic [15:0] q16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    async_reg u_a (
        .clk      (clk),
        .rst      (rst),
        .data_in  (d8),
        .data_out (q8)
    );

    async_reg #(
        .WIDTH           (16),
        .RESET_VALUE     (16'hBEEF),
        .RST_SYNC_STAGES (0)
    ) u_b (
        .clk      (clk),
        .rst      (rst),
        .data_in  (d16),
        .data_out (q16)
    );

    // Reference model: a reset forces the reset value and restarts a count
    // of edges seen since release; capture begins once depth edges have passed.
    int          rel_a = 0;
    logic [7:0]  m8    = 8'h00;
    logic [15:0] m16   = 16'hBEEF;

    always @(posedge rst) begin
        rel_a = 0;
        m8    = 8'h00;
        m16   = 16'hBEEF;
    end

    always @(posedge clk) begin
        if (rst) begin
            rel_a = 0;
            m8    = 8'h00;
            m16   = 16'hBEEF;
        end else begin
            if (rel_a < 2) rel_a = rel_a + 1;
            else m8 = d8;
            m16 = d16;
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] a,
                        input logic [15:0] b);
        @(negedge clk);
        rst = r;
        d8  = a;
        d16 = b;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r;
        logic [7:0]  din8;
        logic [7:0]  exp8;
        logic [15:0] din16;
        logic [15:0] exp16;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1'b1, 8'hA5, 8'h00, 16'h1234, 16'hBEEF};
        vecs[1]  = '{1'b1, 8'hA5, 8'h00, 16'h1234, 16'hBEEF};
        vecs[2]  = '{1'b1, 8'hA5, 8'h00, 16'h1234, 16'hBEEF};
        vecs[3]  = '{1'b0, 8'h00, 8'h00, 16'h1234, 16'h1234};
        vecs[4]  = '{1'b0, 8'h01, 8'h00, 16'h5678, 16'h5678};
        vecs[5]  = '{1'b0, 8'h02, 8'h02, 16'h0001, 16'h0001};
        vecs[6]  = '{1'b0, 8'h03, 8'h03, 16'hFFFF, 16'hFFFF};
        vecs[7]  = '{1'b0, 8'h04, 8'h04, 16'h8000, 16'h8000};
        vecs[8]  = '{1'b0, 8'h05, 8'h05, 16'hA5A5, 16'hA5A5};
        vecs[9]  = '{1'b0, 8'h06, 8'h06, 16'h5A5A, 16'h5A5A};
        vecs[10] = '{1'b0, 8'h07, 8'h07, 16'h00FF, 16'h00FF};

        // Power-up: reset with no clock edge yet.
        #1;
        rst = 1'b1;
        d8  = 8'hA5;
        #1;
        chk("por_a", 64'(q8), 64'h00);
        chk("por_b", 64'(q16), 64'hBEEF);

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].r, vecs[i].din8, vecs[i].din16);
            chk($sformatf("vec%0d_a", i), 64'(q8), 64'(vecs[i].exp8));
            chk($sformatf("vec%0d_b", i), 64'(q16), 64'(vecs[i].exp16));
        end

        // Mid-cycle reset clears at once and holds.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_a", 64'(q8), 64'h00);
        chk("async_b", 64'(q16), 64'hBEEF);
        @(posedge clk);
        #1;
        chk("hold_a", 64'(q8), 64'h00);
        chk("hold_b", 64'(q16), 64'hBEEF);

        // Release while streaming 3C.
        step(1'b0, 8'h3C, 16'h3C3C);
        chk("rel_e1_a", 64'(q8), 64'h00);
        chk("rel_e1_b", 64'(q16), 64'h3C3C);
        step(1'b0, 8'h3C, 16'h3C3C);
        chk("rel_e2_a", 64'(q8), 64'h00);
        step(1'b0, 8'h3C, 16'h3C3C);
        chk("rel_e3_a", 64'(q8), 64'h3C);

        // 1 ns glitch between edges.
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        chk("glitch_a", 64'(q8), 64'h00);
        chk("glitch_b", 64'(q16), 64'hBEEF);
        @(posedge clk);
        #1;
        chk("gl_e1_a", 64'(q8), 64'h00);
        chk("gl_e1_b", 64'(q16), 64'h3C3C);
        step(1'b0, 8'h3C, 16'h3C3C);
        chk("gl_e2_a", 64'(q8), 64'h00);
        step(1'b0, 8'h3C, 16'h3C3C);
        chk("gl_e3_a", 64'(q8), 64'h3C);

        // Randomized run against the model.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 19) == 0);
            d8  = 8'($urandom);
            d16 = 16'($urandom);
            if (!rst && $urandom_range(0, 24) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
            @(posedge clk);
            #1;
            chk("rand_a", 64'(q8), 64'(m8));
            chk("rand_b", 64'(q16), 64'(m16));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
